// File: rtl/loader_pkg.sv
// Shared state encoding and lane/shift helpers for the ioctl ROM loader.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int HOST_AW = 25;

  function automatic int lane_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Lane index needs at least one bit even when a word is a single byte.
  function automatic int lane_idx_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Word FIFO with wrap-bit pointers; head is presented without a read bubble.
module loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IW:0]      r_wptr;
  logic [IW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[IW] != r_rptr[IW]) && (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
  assign o_count = r_wptr - r_rptr;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // Empty head reads as zero so idle outputs stay quiet.
  assign o_rdata = o_empty ? {WIDTH{1'b0}} : r_mem[r_rptr[IW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= {(IW+1){1'b0}};
      r_rptr <= {(IW+1){1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + {{IW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{IW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[IW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/ioctl_rom_loader.sv
// Packs the host ioctl byte stream into little-endian words, buffers them in a
// FIFO and hands them out over a valid/ready word stream.
module ioctl_rom_loader
  import loader_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] INDEX      = 8'h00,
  parameter logic [7:0] PAD        = 8'hFF
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 ioctl_download,
  input  logic                                 ioctl_wr,
  input  logic [24:0]                          ioctl_addr,
  input  logic [7:0]                           ioctl_dout,
  input  logic [7:0]                           ioctl_index,
  output logic                                 ioctl_wait,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [HOST_AW-lane_shift(DATA_W)-1:0] out_addr,
  output logic [DATA_W-1:0]                    out_data,
  output logic [DATA_W/8-1:0]                  out_be,
  output logic                                 done
);

  localparam int LANES = DATA_W / 8;
  localparam int LS    = lane_shift(DATA_W);
  localparam int LIW   = lane_idx_w(DATA_W);
  localparam int AW    = HOST_AW - LS;
  localparam int EW    = AW + DATA_W + LANES;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LIW-1:0] TOP_LANE = LIW'(LANES - 1);
  localparam logic [CW-1:0]  WAIT_LVL = CW'(FIFO_DEPTH - 2);

  state_t              r_state;
  logic                r_dl_prev;
  logic                r_wait;
  logic                r_done;
  logic [DATA_W-1:0]   r_pdata;
  logic [LANES-1:0]    r_pbe;
  logic [AW-1:0]       r_paddr;
  logic                r_pvalid;
  logic                r_ptop;

  logic                w_idx_ok;
  logic                w_start;
  logic                w_take;
  logic                w_same_word;
  logic                w_push;
  logic                w_push_ok;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;
  logic                w_wait_hi;
  logic [LIW-1:0]      w_lane;
  logic [AW-1:0]       w_waddr;
  logic [DATA_W-1:0]   w_ndata;
  logic [LANES-1:0]    w_nbe;
  logic [EW-1:0]       w_rdata;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_count_nxt;

  assign w_idx_ok    = (ioctl_index == INDEX);
  assign w_start     = ioctl_download && !r_dl_prev && w_idx_ok;
  assign w_take      = ioctl_wr && ioctl_download && w_idx_ok &&
                       ((r_state == ST_LOAD) || ((r_state == ST_IDLE) && w_start));
  assign w_lane      = (LS == 0) ? {LIW{1'b0}} : ioctl_addr[LIW-1:0];
  assign w_waddr     = ioctl_addr[24:LS];
  assign w_same_word = r_pvalid && !r_ptop && (w_waddr == r_paddr);

  // A completed word, a word-address jump, or the end of download each push the pending word.
  assign w_push = (r_pvalid && r_ptop) ||
                  (w_take && r_pvalid && !r_ptop && (w_waddr != r_paddr)) ||
                  ((r_state == ST_LOAD) && !ioctl_download && r_pvalid && !r_ptop);

  assign w_pop     = !w_empty && out_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_wait_hi = (w_count_nxt >= WAIT_LVL);

  always_comb begin
    w_ndata = w_same_word ? r_pdata : {LANES{PAD}};
    w_nbe   = w_same_word ? r_pbe : {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (w_lane == LIW'(i)) begin
        w_ndata[8*i +: 8] = ioctl_dout;
        w_nbe[i]          = 1'b1;
      end else begin
        w_nbe[i] = w_nbe[i];
      end
    end
  end

  always_comb begin
    w_count_nxt = w_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = w_count + {{(CW-1){1'b0}}, 1'b1};
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = w_count - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_count_nxt = w_count;
    end
  end

  // Reset leaves r_dl_prev high so a download held across reset is not a new start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_dl_prev <= 1'b1;
      r_wait    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_wait <= w_wait_hi;
          if (w_start) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!ioctl_download) begin
            r_state <= ST_DRAIN;
            r_wait  <= 1'b1;
          end else begin
            r_wait  <= w_wait_hi;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_wait  <= w_wait_hi;
          end else begin
            r_wait  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wait  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pdata  <= {DATA_W{1'b0}};
      r_pbe    <= {LANES{1'b0}};
      r_paddr  <= {AW{1'b0}};
      r_pvalid <= 1'b0;
      r_ptop   <= 1'b0;
    end else if (w_take) begin
      r_pdata  <= w_ndata;
      r_pbe    <= w_nbe;
      r_paddr  <= w_waddr;
      r_pvalid <= 1'b1;
      r_ptop   <= (w_lane == TOP_LANE);
    end else if (w_push) begin
      r_pbe    <= {LANES{1'b0}};
      r_pvalid <= 1'b0;
      r_ptop   <= 1'b0;
    end
  end

  loader_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_wdata ({r_paddr, r_pdata, r_pbe}),
    .i_pop   (out_ready),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign out_valid  = !w_empty;
  assign out_addr   = w_rdata[EW-1 -: AW];
  assign out_data   = w_rdata[LANES +: DATA_W];
  assign out_be     = w_rdata[LANES-1:0];
  assign ioctl_wait = r_wait;
  assign done       = r_done;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed bench: a per-cycle vector table for the 16-bit loader plus hand
// sequences for 8/32-bit packing, FIFO back-pressure and reset mid-download.
module tb_ioctl_rom_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        dl, wr;
  logic [24:0] addr;
  logic [7:0]  dout, idx;
  logic        rdy16, rdy32, rdy4, rdy8;

  logic w16, v16, d16; logic [23:0] a16; logic [15:0] q16; logic [1:0] b16;
  logic w32, v32, d32; logic [22:0] a32; logic [31:0] q32; logic [3:0] b32;
  logic w4,  v4,  d4;  logic [23:0] a4;  logic [15:0] q4;  logic [1:0] b4;
  logic w8,  v8,  d8;  logic [24:0] a8;  logic [7:0]  q8;  logic [0:0] b8;

  ioctl_rom_loader #(.DATA_W(16), .FIFO_DEPTH(8)) dut16 (
    .clock(clock), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx), .ioctl_wait(w16),
    .out_valid(v16), .out_ready(rdy16), .out_addr(a16), .out_data(q16),
    .out_be(b16), .done(d16));

  ioctl_rom_loader #(.DATA_W(32), .FIFO_DEPTH(8)) dut32 (
    .clock(clock), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx), .ioctl_wait(w32),
    .out_valid(v32), .out_ready(rdy32), .out_addr(a32), .out_data(q32),
    .out_be(b32), .done(d32));

  ioctl_rom_loader #(.DATA_W(16), .FIFO_DEPTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx), .ioctl_wait(w4),
    .out_valid(v4), .out_ready(rdy4), .out_addr(a4), .out_data(q4),
    .out_be(b4), .done(d4));

  ioctl_rom_loader #(.DATA_W(8), .FIFO_DEPTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx), .ioctl_wait(w8),
    .out_valid(v8), .out_ready(rdy8), .out_addr(a8), .out_data(q8),
    .out_be(b8), .done(d8));

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        rst;
    logic        dl, wr;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        ev;
    logic [23:0] ea;
    logic [15:0] ed;
    logic [1:0]  eb;
    logic        edn, ew;
  } vec_t;

  vec_t tbl[$];
  logic [41:0] words4[$];

  function automatic vec_t mk(input logic r, input logic d, input logic w, input logic [7:0] ix,
                              input logic [24:0] a, input logic [7:0] dt, input logic ev,
                              input logic [23:0] ea, input logic [15:0] ed, input logic [1:0] eb,
                              input logic edn, input logic ew);
    vec_t t;
    t.rst = r; t.dl = d; t.wr = w; t.idx = ix; t.addr = a; t.dout = dt;
    t.ev = ev; t.ea = ea; t.ed = ed; t.eb = eb; t.edn = edn; t.ew = ew;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic d, input logic w, input logic [7:0] ix,
                      input logic [24:0] a, input logic [7:0] dt);
    dl = d; wr = w; idx = ix; addr = a; dout = dt;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dl = 1'b0; wr = 1'b0; idx = 8'h00; addr = 25'd0; dout = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset_n && v4 && rdy4) words4.push_back({a4, q4, b4});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    dl = 1'b0; wr = 1'b0; idx = 8'h00; addr = 25'd0; dout = 8'h00;
    rdy16 = 1'b1; rdy32 = 1'b1; rdy4 = 1'b0; rdy8 = 1'b0;

    // Four bytes into two full 16-bit words, then drain and done.
    tbl.push_back(mk(1, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd0,8'h11, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd1,8'h22, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd2,8'h33, 1,24'd0,16'h2211,2'b11, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd3,8'h44, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,0,8'h00,25'd0,8'h00, 1,24'd1,16'h4433,2'b11, 0,0));
    tbl.push_back(mk(0, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,1));
    tbl.push_back(mk(0, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 1,0));
    tbl.push_back(mk(0, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    // Word-address jump pushes the padded partial first; end of download flushes the rest.
    tbl.push_back(mk(1, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd0,8'h11, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd6,8'h77, 1,24'd0,16'hFF11,2'b01, 0,0));
    tbl.push_back(mk(0, 1,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 0,0,8'h00,25'd0,8'h00, 1,24'd3,16'hFF77,2'b01, 0,1));
    tbl.push_back(mk(0, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,1));
    tbl.push_back(mk(0, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 1,0));
    tbl.push_back(mk(0, 0,0,8'h00,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    // Foreign index: never starts, writes ignored, late index match without a rising edge ignored.
    tbl.push_back(mk(1, 0,0,8'h05,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,0,8'h05,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h05,25'd0,8'h11, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h05,25'd1,8'h22, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd2,8'h33, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 1,1,8'h00,25'd3,8'h44, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 0,0,8'h05,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));
    tbl.push_back(mk(0, 0,0,8'h05,25'd0,8'h00, 0,24'd0,16'h0000,2'b00, 0,0));

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) begin
        do_reset();
        check($sformatf("reset%0d", k), {v16, a16, q16, b16, d16, w16}, 45'd0);
      end
      step(tbl[k].dl, tbl[k].wr, tbl[k].idx, tbl[k].addr, tbl[k].dout);
      check($sformatf("vec%0d", k), {v16, a16, q16, b16, d16, w16},
            {tbl[k].ev, tbl[k].ea, tbl[k].ed, tbl[k].eb, tbl[k].edn, tbl[k].ew});
    end

    // 32-bit partial flush and 8-bit direct words.
    do_reset();
    rdy8 = 1'b0;
    step(0, 0, 8'h00, 25'd0, 8'h00);
    step(1, 0, 8'h00, 25'd0, 8'h00);
    step(1, 1, 8'h00, 25'd0, 8'hAA);
    step(1, 1, 8'h00, 25'd1, 8'hBB);
    step(1, 1, 8'h00, 25'd2, 8'hCC);
    step(0, 0, 8'h00, 25'd0, 8'h00);
    check("w32_flush", {v32, a32, q32, b32, w32}, {1'b1, 23'd0, 32'hFFCCBBAA, 4'b0111, 1'b1});
    check("w8_head", {v8, a8, q8, b8, w8}, {1'b1, 25'd0, 8'hAA, 1'b1, 1'b1});
    rdy8 = 1'b1;
    step(0, 0, 8'h00, 25'd0, 8'h00);
    check("w32_popped", {v32, d32}, 2'b00);
    check("w8_next", {v8, a8, q8, b8}, {1'b1, 25'd1, 8'hBB, 1'b1});
    step(0, 0, 8'h00, 25'd0, 8'h00);
    check("w32_done", d32, 1'b1);
    step(0, 0, 8'h00, 25'd0, 8'h00);
    check("w32_done_pulse", d32, 1'b0);

    // Depth-4 FIFO stalled: host honours wait, then all words drain in order.
    do_reset();
    rdy4 = 1'b0;
    words4.delete();
    step(0, 0, 8'h00, 25'd0, 8'h00);
    step(1, 0, 8'h00, 25'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'h00, 25'(i), 8'h10 + 8'(i));
      if (i == 3) check("fifo4_wait_low", w4, 1'b0);
    end
    check("fifo4_wait_high", w4, 1'b1);
    check("fifo4_head", {v4, a4, q4, b4}, {1'b1, 24'd0, 16'h1110, 2'b11});
    repeat (3) step(1, 0, 8'h00, 25'd0, 8'h00);
    check("fifo4_hold", {w4, v4, a4, q4, b4}, {1'b1, 1'b1, 24'd0, 16'h1110, 2'b11});
    rdy4 = 1'b1;
    begin
      int nxt;
      int budget;
      nxt = 5;
      budget = 0;
      while (nxt < 8 && budget < 60) begin
        if (!w4) begin
          step(1, 1, 8'h00, 25'(nxt), 8'h10 + 8'(nxt));
          nxt++;
        end else begin
          step(1, 0, 8'h00, 25'd0, 8'h00);
        end
        budget++;
      end
      check("fifo4_host_bytes", nxt, 8);
      step(0, 0, 8'h00, 25'd0, 8'h00);
      budget = 0;
      while (!d4 && budget < 60) begin
        step(0, 0, 8'h00, 25'd0, 8'h00);
        budget++;
      end
      check("fifo4_done_seen", d4, 1'b1);
    end
    check("fifo4_word_count", words4.size(), 4);
    for (int k = 0; k < 4; k++) begin
      logic [41:0] exp_w;
      logic [7:0]  lo;
      lo = 8'h10 + 8'(2 * k);
      exp_w = {24'(k), lo + 8'h01, lo, 2'b11};
      if (k < words4.size()) check($sformatf("fifo4_word%0d", k), words4[k], exp_w);
      else check($sformatf("fifo4_word%0d", k), 42'd0, exp_w);
    end

    // Reset mid-download: outputs clear at once and nothing resumes without a new start.
    do_reset();
    rdy16 = 1'b0;
    step(0, 0, 8'h00, 25'd0, 8'h00);
    step(1, 0, 8'h00, 25'd0, 8'h00);
    step(1, 1, 8'h00, 25'd0, 8'h11);
    step(1, 1, 8'h00, 25'd1, 8'h22);
    step(1, 1, 8'h00, 25'd2, 8'h33);
    check("rst_pre_valid", {v16, a16, q16, b16}, {1'b1, 24'd0, 16'h2211, 2'b11});
    #2 reset_n = 1'b0;
    #1;
    check("rst_async16", {v16, a16, q16, b16, d16, w16}, 45'd0);
    check("rst_async4", {v4, a4, q4, b4, d4, w4}, 45'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1, 1, 8'h00, 25'd3, 8'h44);
    step(1, 1, 8'h00, 25'd4, 8'h55);
    step(1, 1, 8'h00, 25'd5, 8'h66);
    step(1, 0, 8'h00, 25'd0, 8'h00);
    check("rst_no_output", {v16, w16}, 2'b00);
    step(0, 0, 8'h00, 25'd0, 8'h00);
    step(0, 0, 8'h00, 25'd0, 8'h00);
    check("rst_no_done", {v16, d16}, 2'b00);
    step(1, 0, 8'h00, 25'd0, 8'h00);
    step(1, 1, 8'h00, 25'd8, 8'h66);
    step(1, 1, 8'h00, 25'd9, 8'h77);
    step(1, 0, 8'h00, 25'd0, 8'h00);
    check("rst_recover", {v16, a16, q16, b16}, {1'b1, 24'd4, 16'h7766, 2'b11});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
